// File: rtl/instr_packer.sv
// Packs decoded LDUR/STUR/CBZ/CBNZ fields into 32-bit words and streams them to instruction memory.
// One word in flight: accept in IDLE, present registered write until wr_ack; start restarts the program.
module instr_packer #(
  parameter int AW        = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_kind,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rn,
  input  logic [31:0]   in_off,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  input  logic          wr_ack,
  output logic          full,
  output logic          err,
  output logic [7:0]    err_count,
  output logic [AW:0]   word_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] BASE_C  = AW'(BASE_ADDR);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [AW:0]   wc_q, wc_d;
  logic [7:0]    ec_q, ec_d;
  logic          err_q, err_d;

  logic          d_ok, cb_ok, in_range;
  logic [31:0]   enc;

  // An offset fits when every bit above the field's sign bit matches that sign bit.
  assign d_ok  = (&in_off[31:8])  | ~(|in_off[31:8]);
  assign cb_ok = (&in_off[31:18]) | ~(|in_off[31:18]);

  always_comb begin
    in_range = 1'b0;
    enc      = '0;
    case (in_kind)
      2'd0: begin
        in_range = d_ok;
        enc      = {11'b11111000010, in_off[8:0], 2'b00, in_rn, in_rt};
      end
      2'd1: begin
        in_range = d_ok;
        enc      = {11'b11111000000, in_off[8:0], 2'b00, in_rn, in_rt};
      end
      2'd2: begin
        in_range = cb_ok;
        enc      = {8'b10110100, in_off[18:0], in_rt};
      end
      default: begin
        in_range = cb_ok;
        enc      = {8'b10110101, in_off[18:0], in_rt};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wc_d    = wc_q;
    ec_d    = ec_q;
    err_d   = 1'b0;
    if (start) begin
      state_d = S_IDLE;
      addr_d  = BASE_C;
      wc_d    = '0;
      ec_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (in_range) begin
              state_d = S_WRITE;
              data_d  = enc;
            end else begin
              err_d = 1'b1;
              if (ec_q != 8'hFF) ec_d = ec_q + 8'd1;
            end
          end
        end
        S_WRITE: begin
          if (wr_ack) begin
            wc_d    = wc_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = ((wc_q + 1'b1) == DEPTH_C) ? S_FULL : S_IDLE;
          end
        end
        S_FULL:  state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_C;
      data_q  <= '0;
      wc_q    <= '0;
      ec_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wc_q    <= wc_d;
      ec_q    <= ec_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = rst_n && (state_q == S_IDLE);
  assign wr_en      = (state_q == S_WRITE);
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign full       = (state_q == S_FULL);
  assign err        = err_q;
  assign err_count  = ec_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_instr_packer.sv
// Directed plus randomized bench for instr_packer, checked against an arithmetic model of the encoding.
module tb_instr_packer;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int BASE  = 0;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, wr_ack;
  logic [1:0]    in_kind;
  logic [4:0]    in_rt, in_rn;
  logic [31:0]   in_off;
  logic          in_ready, wr_en, full, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [7:0]    err_count;
  logic [AW:0]   word_count;

  always #5 clk = ~clk;

  instr_packer #(.AW(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rt(in_rt), .in_rn(in_rn), .in_off(in_off),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .full(full), .err(err), .err_count(err_count), .word_count(word_count)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m_addr, m_wc, m_ec;
  bit          m_full;
  logic [31:0] last_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_in_range(input int kind, input longint off);
    if (kind < 2) return (off >= -256) && (off <= 255);
    return (off >= -262144) && (off <= 262143);
  endfunction

  function automatic logic [31:0] model_word(input int kind, input int rt, input int rn, input longint off);
    longint w;
    if (kind < 2) begin
      w = (kind == 0 ? 64'h7C2 : 64'h7C0) * (64'd1 << 21)
        + (((off % 512) + 512) % 512) * 4096 + rn * 32 + rt;
    end else begin
      w = (kind == 2 ? 64'hB4 : 64'hB5) * (64'd1 << 24)
        + (((off % 524288) + 524288) % 524288) * 32 + rt;
    end
    return w[31:0];
  endfunction

  // Recover the offset the way the CPU's immediate path would.
  function automatic longint decode_off(input logic [31:0] w);
    longint v;
    if (w[26]) begin
      v = longint'(w[23:5]);
      if (v >= 262144) v -= 524288;
    end else begin
      v = longint'(w[20:12]);
      if (v >= 256) v -= 512;
    end
    return v;
  endfunction

  task automatic model_clear();
    m_addr = BASE; m_wc = 0; m_ec = 0; m_full = 0;
  endtask

  task automatic chk_reset_vals(input bit in_rst);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, BASE);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_in_ready", in_ready, !in_rst);
  endtask

  task automatic send(input int kind, input int rt, input int rn, input longint off, input int delay);
    logic [31:0] exp_w;
    in_kind = 2'(kind); in_rt = 5'(rt); in_rn = 5'(rn); in_off = off[31:0]; in_valid = 1'b1;
    chk("in_ready_pre", in_ready, !m_full);
    if (m_full) begin
      tick();
      in_valid = 1'b0;
      chk("held_wr_en", wr_en, 0);
      chk("held_ready", in_ready, 0);
      chk("held_full", full, 1);
      chk("held_wc", word_count, m_wc);
      return;
    end
    tick();
    in_valid = 1'b0;
    if (model_in_range(kind, off)) begin
      exp_w  = model_word(kind, rt, rn, off);
      last_w = wr_data;
      chk("wr_en", wr_en, 1);
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, exp_w);
      chk("roundtrip", decode_off(wr_data), off);
      chk("err_low", err, 0);
      for (int d = 0; d < delay; d++) begin
        chk("busy_ready", in_ready, 0);
        tick();
        chk("hold_en", wr_en, 1);
        chk("hold_addr", wr_addr, m_addr);
        chk("hold_data", wr_data, exp_w);
        chk("hold_wc", word_count, m_wc);
      end
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      m_wc++;
      m_addr = (m_addr + 1) % (1 << AW);
      if (m_wc == DEPTH) m_full = 1;
      chk("wr_en_drop", wr_en, 0);
      chk("word_count", word_count, m_wc);
      chk("addr_next", wr_addr, m_addr);
      chk("full", full, m_full);
      chk("ready_post", in_ready, !m_full);
    end else begin
      if (m_ec < 255) m_ec++;
      chk("err_pulse", err, 1);
      chk("err_count", err_count, m_ec);
      chk("err_no_wr", wr_en, 0);
      chk("err_ready", in_ready, 1);
      tick();
      chk("err_clear", err, 0);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    chk("start_wr_en", wr_en, 0);
    chk("start_addr", wr_addr, BASE);
    chk("start_wc", word_count, 0);
    chk("start_ec", err_count, 0);
    chk("start_full", full, 0);
    chk("start_ready", in_ready, 1);
  endtask

  initial begin
    longint bnd [8] = '{-257, -256, 255, 256, -262145, -262144, 262143, 262144};
    longint off;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; wr_ack = 1'b0;
    in_kind = '0; in_rt = '0; in_rn = '0; in_off = '0;
    model_clear();
    #12;
    chk_reset_vals(1'b1);
    rst_n = 1'b1;
    tick();
    chk_reset_vals(1'b0);

    send(0, 3, 5, -1, 0);
    chk("ldur_vector", last_w, 32'hF85FF0A3);
    send(2, 7, 9, 4, 1);
    chk("cbz_vector", last_w, 32'hB4000087);
    send(3, 1, 0, -262144, 2);
    do_start();

    send(0, 1, 2, 256, 0);
    send(1, 1, 2, -257, 0);
    send(0, 4, 6, 255, 3);
    send(1, 8, 10, -256, 0);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk("stray_ack_wc", word_count, m_wc);
    chk("stray_ack_en", wr_en, 0);
    send(2, 2, 0, 100, 0);
    send(3, 3, 0, -5, 1);
    send(0, 1, 1, 7, 0);
    do_start();

    // start wins over a same-cycle accept
    in_kind = 2'd0; in_rt = 5'd1; in_rn = 5'd1; in_off = 32'd3; in_valid = 1'b1; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    chk("start_vs_accept_en", wr_en, 0);
    chk("start_vs_accept_wc", word_count, 0);

    // start wins over a same-cycle wr_ack
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pending_en", wr_en, 1);
    start = 1'b1; wr_ack = 1'b1;
    tick();
    start = 1'b0; wr_ack = 1'b0;
    chk("start_vs_ack_en", wr_en, 0);
    chk("start_vs_ack_wc", word_count, 0);
    chk("start_vs_ack_addr", wr_addr, BASE);
    chk("start_vs_ack_full", full, 0);

    // reset mid-write
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_en", wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals(1'b1);
    tick();
    rst_n = 1'b1;
    model_clear();
    tick();
    chk_reset_vals(1'b0);

    for (int i = 0; i < 260; i++) send(0, 0, 0, 1000, 0);
    do_start();

    for (int i = 0; i < 120; i++) begin
      if (m_full && $urandom_range(0, 1) == 1) begin
        do_start();
      end else begin
        case ($urandom_range(0, 3))
          0:       off = longint'($urandom_range(0, 511)) - 256;
          1:       off = longint'($urandom_range(0, 524287)) - 262144;
          2:       off = bnd[$urandom_range(0, 7)];
          default: off = longint'(int'($urandom()));
        endcase
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), off, int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
